// File: rtl/alu_pkg.sv
// Shared types and widths for the execute/writeback stage: opcodes, the
// writeback entry layout and the operand/register widths.
package alu_pkg;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 3;
  localparam int NREG    = 2 ** ADDR_W;
  localparam int SHAMT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SLL  = 3'b101,
    OP_SRL  = 3'b110,
    OP_HALT = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order writeback queue of {dest, data} entries. Each slot carries an
// occupancy bit, so full/empty and the pending-destination mask all come from
// registered state.
module wb_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  wb_entry_t       entry_i,
  input  logic            pop_i,
  output logic            full_o,
  output logic            empty_o,
  output wb_entry_t       head_o,
  output logic [NREG-1:0] dest_mask_o
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  logic [DEPTH-1:0] occ_q;
  logic [DEPTH-1:0] occ_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = &occ_q;
  assign empty_o = ~|occ_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Push and pop never address the same slot: that would need the queue to be
  // both full and empty, so the set and clear below cannot collide.
  always_comb begin
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      occ_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      occ_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_q[gi] <= '0;
      end else if (do_push && (wr_ptr_q == PTR_W'(gi))) begin
        mem_q[gi] <= entry_i;
      end
    end
  end

  // Duplicate destinations simply OR together, so a bit stays set until the
  // last entry aimed at that register has left.
  always_comb begin
    dest_mask_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occ_q[i]) begin
        dest_mask_o[mem_q[i].dest] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_exec_wb.sv
// Execute/writeback stage: combinational ALU, registered flags, RUN->HALTED
// state and a small in-order queue draining into the register-file write port.
module alu_exec_wb
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [ADDR_W-1:0] in_dest,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic              flag_ovf,
  output logic [NREG-1:0]   pending_mask,
  output logic              halted,
  output logic              drained
);

  typedef enum logic {ST_RUN, ST_HALTED} state_e;

  state_e            state_q, state_d;
  logic              zero_q, zero_d;
  logic              carry_q, carry_d;
  logic              ovf_q, ovf_d;
  alu_op_e           op;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] result;
  logic              res_carry;
  logic              res_ovf;
  logic              accept;
  logic              is_halt;
  logic              fifo_full;
  logic              fifo_empty;
  wb_entry_t         push_entry;
  wb_entry_t         head;

  assign op      = alu_op_e'(in_op);
  assign is_halt = (op == OP_HALT);
  assign sum     = {1'b0, in_a} + {1'b0, in_b};

  always_comb begin
    result    = '0;
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    unique case (op)
      OP_ADD: begin
        result    = sum[DATA_W-1:0];
        res_carry = sum[DATA_W];
        res_ovf   = (in_a[DATA_W-1] == in_b[DATA_W-1]) && (result[DATA_W-1] != in_a[DATA_W-1]);
      end
      OP_SUB: begin
        result    = in_a - in_b;
        res_carry = (in_a < in_b);
        res_ovf   = (in_a[DATA_W-1] != in_b[DATA_W-1]) && (result[DATA_W-1] != in_a[DATA_W-1]);
      end
      OP_AND:  result = in_a & in_b;
      OP_OR:   result = in_a | in_b;
      OP_XOR:  result = in_a ^ in_b;
      OP_SLL:  result = in_a << in_b[SHAMT_W-1:0];
      OP_SRL:  result = in_a >> in_b[SHAMT_W-1:0];
      OP_HALT: result = '0;
    endcase
  end

  // in_ready depends only on registered state, never on wb_ready.
  assign in_ready = !fifo_full && (state_q == ST_RUN);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_RUN: begin
        if (accept && is_halt) begin
          state_d = ST_HALTED;
        end else if (accept) begin
          zero_d  = (result == '0);
          carry_d = res_carry;
          ovf_d   = res_ovf;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign push_entry.dest = in_dest;
  assign push_entry.data = result;

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (accept && !is_halt),
    .entry_i    (push_entry),
    .pop_i      (wb_valid && wb_ready),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (head),
    .dest_mask_o(pending_mask)
  );

  assign wb_valid   = !fifo_empty;
  assign wb_addr    = head.dest;
  assign wb_data    = head.data;
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;
  assign flag_ovf   = ovf_q;
  assign halted     = (state_q == ST_HALTED);
  assign drained    = halted && fifo_empty;

endmodule

// File: tb/tb_alu_exec_wb.sv
// Bench for alu_exec_wb: writes are scored against a queue of expected
// {dest, data} filled when each op is accepted; flags come from a small model.
module tb_alu_exec_wb;
  import alu_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [ADDR_W-1:0] in_dest;
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              flag_zero, flag_carry, flag_ovf;
  logic [NREG-1:0]   pending_mask;
  logic              halted, drained;

  int n_assert = 0;
  int n_fail   = 0;
  int wr_count = 0;
  logic [ADDR_W+DATA_W-1:0] sb_q[$];
  logic exp_zero, exp_carry, exp_ovf;

  always #5 clk = ~clk;

  alu_exec_wb #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_dest(in_dest),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_ovf(flag_ovf),
    .pending_mask(pending_mask), .halted(halted), .drained(drained)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Reference ALU returns {carry, ovf, result}.
  function automatic logic [DATA_W+1:0] model(input logic [2:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0]   s;
    logic [DATA_W-1:0] r;
    logic              c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[DATA_W-1:0];
        c = s[DATA_W];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd1: begin
        r = a - b;
        c = (a < b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << b[4:0];
      3'd6: r = a >> b[4:0];
      default: r = '0;
    endcase
    return {c, v, r};
  endfunction

  // Write monitor: every accepted write must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && wb_valid && wb_ready) begin
      wr_count++;
      if (sb_q.size() == 0) begin
        check("wb_unexpected", 64'(wb_addr), 64'hFF);
      end else begin
        logic [ADDR_W+DATA_W-1:0] e;
        e = sb_q.pop_front();
        check("wb_addr", 64'(wb_addr), 64'(e[ADDR_W+DATA_W-1:DATA_W]));
        check("wb_data", 64'(wb_data), 64'(e[DATA_W-1:0]));
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [DATA_W-1:0] a,
                      input logic [DATA_W-1:0] b, input logic [ADDR_W-1:0] d);
    logic [DATA_W+1:0] m;
    bit ok;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_dest = d;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) begin
      check("send_timeout", 64'd0, 64'd1);
    end else begin
      if (op != 3'd7) begin
        m = model(op, a, b);
        sb_q.push_back({d, m[DATA_W-1:0]});
        exp_carry = m[DATA_W+1];
        exp_ovf   = m[DATA_W];
        exp_zero  = (m[DATA_W-1:0] == '0);
      end
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_zero"},  64'(flag_zero),  64'(exp_zero));
    check({tag, "_carry"}, 64'(flag_carry), 64'(exp_carry));
    check({tag, "_ovf"},   64'(flag_ovf),   64'(exp_ovf));
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk); #1;
      done = !wb_valid && (sb_q.size() == 0);
    end
    if (!done) check("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb_q.delete();
    exp_zero = 1'b0; exp_carry = 1'b0; exp_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    logic [NREG-1:0] masks [4];
    masks[0] = 8'h24; masks[1] = 8'h24; masks[2] = 8'h20; masks[3] = 8'h00;
    in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_dest = '0; wb_ready = 1'b1;
    do_reset();

    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_pending",  64'(pending_mask), 64'd0);
    check("rst_halted",   64'(halted), 64'd0);
    check("rst_drained",  64'(drained), 64'd0);
    check("rst_wb_addr",  64'(wb_addr), 64'd0);
    check("rst_wb_data",  64'(wb_data), 64'd0);
    check_flags("rst");

    // Signed overflow on ADD, with single-cycle latency to wb_valid.
    send(3'd0, 32'h7FFF_FFFF, 32'd1, 3'd3);
    check("lat_wb_valid", 64'(wb_valid), 64'd1);
    check("lat_wb_addr",  64'(wb_addr), 64'd3);
    check("lat_wb_data",  64'(wb_data), 64'h8000_0000);
    check("add_ovf",   64'(flag_ovf), 64'd1);
    check("add_carry", 64'(flag_carry), 64'd0);
    check("add_zero",  64'(flag_zero), 64'd0);

    send(3'd1, 32'd5, 32'd5, 3'd1);
    check("sub0_zero",  64'(flag_zero), 64'd1);
    check("sub0_carry", 64'(flag_carry), 64'd0);
    send(3'd1, 32'd3, 32'd5, 3'd2);
    check("sub1_zero",  64'(flag_zero), 64'd0);
    check("sub1_carry", 64'(flag_carry), 64'd1);
    send(3'd5, 32'd1, 32'h23, 3'd4);
    send(3'd6, 32'h8000_0000, 32'd31, 3'd5);
    check_flags("shift");
    wait_drain();

    for (int i = 0; i < 10; i++) begin
      send(3'($urandom_range(0, 6)), $urandom, (i % 3 == 0) ? 32'h8000_0000 : $urandom,
           3'($urandom_range(0, 7)));
      check_flags("rand");
    end
    wait_drain();

    // Fill with the register file stalled, then drain and watch the mask.
    wb_ready = 1'b0;
    send(3'd0, 32'd10, 32'd1, 3'd1);
    send(3'd2, 32'hF0F0, 32'hFF00, 3'd2);
    send(3'd3, 32'h1, 32'h2, 3'd2);
    send(3'd4, 32'hAAAA, 32'h5555, 3'd5);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_pending",  64'(pending_mask), 64'h26);
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("drain_pending_%0d", i), 64'(pending_mask), 64'(masks[i]));
      if (i == 0) check("pop_in_ready", 64'(in_ready), 64'd1);
    end
    wait_drain();

    // HALT with a write still queued, then keep offering ops.
    wb_ready = 1'b0;
    base = wr_count;
    send(3'd0, 32'hFFFF_FFFF, 32'd2, 3'd6);
    send(3'd7, 32'd0, 32'd0, 3'd0);
    check("halt_halted", 64'(halted), 64'd1);
    in_valid = 1'b1; in_op = 3'd0; in_a = 32'd0; in_b = 32'd0; in_dest = 3'd7;
    repeat (3) @(posedge clk);
    #1;
    check("halt_in_ready", 64'(in_ready), 64'd0);
    check("halt_drained0", 64'(drained), 64'd0);
    wb_ready = 1'b1;
    wait_drain();
    check("halt_drained1", 64'(drained), 64'd1);
    check("halt_writes", 64'(wr_count - base), 64'd1);
    check_flags("halt");
    in_valid = 1'b0;

    do_reset();
    check("rst2_halted",   64'(halted), 64'd0);
    check("rst2_in_ready", 64'(in_ready), 64'd1);

    // Asynchronous reset with three entries in flight.
    wb_ready = 1'b0;
    send(3'd0, 32'd1, 32'd1, 3'd1);
    send(3'd0, 32'd2, 32'd2, 3'd3);
    send(3'd0, 32'd3, 32'd3, 3'd7);
    check("pre_rst_pending", 64'(pending_mask), 64'h8A);
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("async_wb_valid", 64'(wb_valid), 64'd0);
    check("async_pending",  64'(pending_mask), 64'd0);
    check("async_halted",   64'(halted), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wb_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_wb_valid", 64'(wb_valid), 64'd0);
    check_flags("post_rst");

    repeat (2) @(posedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
